// File: rtl/lfsr_checker_if.sv
// Sample-stream bundle between an XNOR LFSR source and its checker.
// The source side drives samples and the count clear; the checker returns status.
interface lfsr_checker_if #(
    parameter int N  = 3,
    parameter int CW = 8
);
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          clear_count;
    logic          locked;
    logic          err;
    logic          lockup;
    logic [CW-1:0] err_count;

    modport master (
        output in_valid, in_data, clear_count,
        input  locked, err, lockup, err_count
    );

    modport slave (
        input  in_valid, in_data, clear_count,
        output locked, err, lockup, err_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// Tracks an N-bit XNOR LFSR sample stream: predicts each next sample, tracks lock,
// and reports per-sample mismatches, the all-ones lock-up state and a saturating error count.
module lfsr_checker #(
    parameter int N           = 3,
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 2,
    parameter int CW          = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    lfsr_checker_if.slave  bus
);
    localparam int MAXT = (LOCK_THRESH > LOSS_THRESH) ? LOCK_THRESH : LOSS_THRESH;
    localparam int RW   = $clog2(MAXT + 1);
    localparam int RW1  = RW + 1;

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  ref_q, ref_d;
    logic          have_ref_q, have_ref_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic          err_q, err_d;
    logic          lockup_q, lockup_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [RW1-1:0] run_inc;
    logic           match;

    function automatic logic [N-1:0] predict(input logic [N-1:0] r);
        return {r[N-2:0], ~(r[N-1] ^ r[N-2])};
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // All-ones is the XNOR lock-up point: it predicts itself but is never a valid step.
    assign match   = have_ref_q && (bus.in_data == predict(ref_q)) && !(&bus.in_data);
    assign run_inc = {1'b0, run_cnt_q} + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= UNLOCKED;
            ref_q      <= '0;
            have_ref_q <= 1'b0;
            run_cnt_q  <= '0;
            err_q      <= 1'b0;
            lockup_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            have_ref_q <= have_ref_d;
            run_cnt_q  <= run_cnt_d;
            err_q      <= err_d;
            lockup_q   <= lockup_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        have_ref_d = have_ref_q;
        run_cnt_d  = run_cnt_q;
        err_d      = 1'b0;
        lockup_d   = lockup_q;
        cnt_d      = cnt_q;

        if (bus.in_valid) begin
            ref_d      = bus.in_data;
            have_ref_d = 1'b1;
            lockup_d   = &bus.in_data;
            // The first sample after reset only seeds the reference.
            if (have_ref_q) begin
                case (state_q)
                    UNLOCKED: begin
                        if (match) begin
                            if (run_inc == RW1'(LOCK_THRESH)) begin
                                state_d   = LOCKED;
                                run_cnt_d = '0;
                            end else begin
                                run_cnt_d = run_inc[RW-1:0];
                            end
                        end else begin
                            run_cnt_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            run_cnt_d = '0;
                        end else begin
                            err_d = 1'b1;
                            cnt_d = sat_inc(cnt_q);
                            if (run_inc == RW1'(LOSS_THRESH)) begin
                                state_d   = UNLOCKED;
                                run_cnt_d = '0;
                            end else begin
                                run_cnt_d = run_inc[RW-1:0];
                            end
                        end
                    end
                    default: state_d = UNLOCKED;
                endcase
            end
        end

        if (bus.clear_count) cnt_d = '0;
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err       = err_q;
    assign bus.lockup    = lockup_q;
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: table of samples with hand-computed status,
// plus hand sequences for saturation/clear and asynchronous reset.
module tb_lfsr_checker;
    logic clk = 1'b0;
    logic rst1_n, rst2_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lfsr_checker_if #(.N(3), .CW(8)) if1 ();
    lfsr_checker_if #(.N(3), .CW(2)) if2 ();

    lfsr_checker #(.N(3), .LOCK_THRESH(4), .LOSS_THRESH(2), .CW(8)) dut1 (
        .clk(clk), .reset_n(rst1_n), .bus(if1.slave));
    lfsr_checker #(.N(3), .LOCK_THRESH(4), .LOSS_THRESH(8), .CW(2)) dut2 (
        .clk(clk), .reset_n(rst2_n), .bus(if2.slave));

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic       c;
        logic       l;
        logic       e;
        logic       u;
        logic [7:0] n;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [2:0] d, input logic c,
                       input logic l, input logic e, input logic u, input logic [7:0] n);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.l = l; r.e = e; r.u = u; r.n = n;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic l, input logic e, input logic u, input logic [7:0] n);
        chk({tag, ".locked"},    32'(if1.locked),    32'(l));
        chk({tag, ".err"},       32'(if1.err),       32'(e));
        chk({tag, ".lockup"},    32'(if1.lockup),    32'(u));
        chk({tag, ".err_count"}, 32'(if1.err_count), 32'(n));
    endtask

    task automatic chk2(input string tag, input logic l, input logic e, input logic [1:0] n);
        chk({tag, ".locked"},    32'(if2.locked),    32'(l));
        chk({tag, ".err"},       32'(if2.err),       32'(e));
        chk({tag, ".err_count"}, 32'(if2.err_count), 32'(n));
    endtask

    task automatic step1(input logic v, input logic [2:0] d, input logic c);
        @(negedge clk);
        if1.in_valid = v; if1.in_data = d; if1.clear_count = c;
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0; if1.clear_count = 1'b0;
    endtask

    task automatic step2(input logic v, input logic [2:0] d, input logic c);
        @(negedge clk);
        if2.in_valid = v; if2.in_data = d; if2.clear_count = c;
        @(posedge clk);
        #1;
        if2.in_valid = 1'b0; if2.clear_count = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if1.in_valid = 1'b0; if1.in_data = '0; if1.clear_count = 1'b0;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.clear_count = 1'b0;
        rst1_n = 1'b0; rst2_n = 1'b0;
        #1;
        chk1("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        chk2("reset2", 1'b0, 1'b0, 2'd0);
        @(negedge clk); @(negedge clk);
        rst1_n = 1'b1; rst2_n = 1'b1;

        //   v     d      clr   locked err  lockup count
        add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        add(1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
        add(1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
        add(1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        add(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        add(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        add(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        add(1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        add(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        add(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        add(1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        for (int k = 0; k < 5; k++)
            add(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        add(1'b1, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        add(1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
        add(1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
        add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        add(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step1(tbl[i].v, tbl[i].d, tbl[i].c);
            chk1($sformatf("row%0d", i), tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].n);
        end

        // Saturation at CW=2 with a wide loss threshold, then clear racing an increment.
        step2(1'b1, 3'b000, 1'b0);
        step2(1'b1, 3'b001, 1'b0);
        step2(1'b1, 3'b011, 1'b0);
        step2(1'b1, 3'b110, 1'b0);
        step2(1'b1, 3'b101, 1'b0);
        chk2("sat.lock", 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            step2(1'b1, 3'b101, 1'b0);
            chk2($sformatf("sat.mm%0d", k), 1'b1, 1'b1, (k >= 3) ? 2'd3 : 2'(k));
        end
        step2(1'b1, 3'b101, 1'b1);
        chk2("sat.clear", 1'b1, 1'b1, 2'd0);

        // Asynchronous reset mid-operation, then a fresh reference is required.
        step1(1'b1, 3'b000, 1'b1);
        step1(1'b1, 3'b001, 1'b0);
        step1(1'b1, 3'b011, 1'b0);
        step1(1'b1, 3'b110, 1'b0);
        step1(1'b1, 3'b101, 1'b0);
        step1(1'b1, 3'b101, 1'b0);
        step1(1'b1, 3'b010, 1'b0);
        step1(1'b1, 3'b010, 1'b0);
        chk1("pre_rst", 1'b1, 1'b1, 1'b0, 8'd2);
        #2;
        rst1_n = 1'b0;
        #1;
        chk1("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst1_n = 1'b1;
        step1(1'b1, 3'b010, 1'b0);
        chk1("post_ref", 1'b0, 1'b0, 1'b0, 8'd0);
        step1(1'b1, 3'b100, 1'b0);
        chk1("post_match", 1'b0, 1'b0, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side companion to the game's N-bit XNOR LFSR generator. It takes the generator's parallel state samples, predicts each next sample with the same feedback rule, and reports lock status, per-sample mismatches, the all-ones lock-up state, and a saturating error count. It sits on the sampled output of a pseudo-random source, such as an obstacle or coin spawner, to confirm in hardware that the stream is sequencing correctly.

Parameters:
N, 3, LFSR width; must be >= 2
LOCK_THRESH, 4, consecutive correct transitions required to enter LOCKED; must be >= 1
LOSS_THRESH, 2, consecutive mismatches in LOCKED that force UNLOCKED; must be >= 1
CW, 8, width of err_count

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  in_data carries a new sample this cycle
in_data  in  N  sampled LFSR state
clear_count  in  1  synchronous clear of err_count
locked  out  1  checker is synchronised to the stream
err  out  1  one-cycle pulse per mismatch counted in LOCKED
lockup  out  1  last accepted sample was all-ones
err_count  out  CW  saturating count of mismatches seen in LOCKED

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While reset_n = 0, clear immediately with no clock edge required: locked=0, err=0, lockup=0, err_count=0, ref_q=0, have_ref=0, run_cnt=0, state=UNLOCKED.
- Prediction: pred = {ref_q[N-2:0], ~(ref_q[N-1] ^ ref_q[N-2])}.
  - ref_q holds the last accepted sample.
  - For N=3 the sequence is 000>001>011>110>101>010>100>000 (period 7). 111 maps to itself.
- Accepting a sample: a sample is accepted on a rising edge with in_valid=1.
  - ref_q <= in_data and have_ref <= 1.
  - match = have_ref and (in_data == pred) and (in_data != all-ones).
  - The first sample after reset is a reference only. It is neither a match nor a mismatch.
- Gaps: in_valid=0 cycles are ignored. State, counters and outputs hold, except err, which returns to 0. The next accepted sample is compared one step from the last accepted one.
- State UNLOCKED:
  - match: run_cnt++. When run_cnt+1 == LOCK_THRESH, go to LOCKED and set run_cnt=0.
  - mismatch: run_cnt=0.
  - No err pulses and no counting in this state.
- State LOCKED:
  - match: run_cnt=0.
  - mismatch: err=1 for one cycle, err_count saturating +1, run_cnt++. When run_cnt+1 == LOSS_THRESH, go to UNLOCKED and set run_cnt=0.
- lockup is updated only on accepted samples: lockup <= (in_data == all-ones). An all-ones sample is always a mismatch.
- Latency: all outputs are registered and reflect a sample on the edge that accepts it, i.e. they are visible in the following cycle.
- locked is the registered state (LOCKED = 1).
- err_count saturates at 2^CW-1 and never wraps.
- clear_count=1 sets err_count=0 on that edge. If an increment occurs on the same edge, clear wins and the result is 0. State and err are not affected.
- Reset mid-operation abandons lock and history. A fresh reference sample is needed afterwards.

Test Plan:
1. Reset, then consecutive valid samples 000,001,011,110,101 -> locked=1 after the edge accepting 101 (4 matches); err never asserted; err_count=0.
2. Locked after 1, feed 100 (expected 010) -> err high exactly one cycle, err_count=1, locked stays 1. Then feed 000 (matches 100) -> no err. Then two wrong samples 011,011 -> err_count=3, locked=0 after the second.
3. Locked; samples 001,011, then in_valid=0 for 5 cycles, then 110 -> no err, locked stays 1, outputs constant during the gap.
4. Locked, feed 111 -> lockup=1, err pulse, err_count+1. Feed 111 again -> second mismatch, locked=0, lockup stays 1. Feed 000 -> lockup=0.
5. CW=2, LOSS_THRESH=8, locked, 5 consecutive mismatches -> err_count reaches 3 and holds; locked stays 1. Then clear_count asserted with a mismatch on the same edge -> err_count=0 and err=1.
6. Locked with err_count=2, drive reset_n low between clock edges -> locked, err, lockup, err_count all 0 before the next edge. Release, feed 010,100 -> one match only, locked=0.
